output_io_arb: RTL and testbench

OUTPUT_IO_ARB -- requirements
Module: output_io_arb

---
 rtl/output_io_arb.sv | 147 ++++++++++++++
 tb/tb_output_io_arb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/output_io_arb.sv
// output_io_arb
//   Round-robin arbiter that lets NREQ fabric requesters take turns driving a
//   single output pad lane.
//
//   Each ownership runs through the same sequence:
//     IDLE  : pick a winner from PTR upward, with wrap-around.
//     GRANT : stream the owner's DIN to OQI with one cycle of latency.
//     TURN  : one quiet cycle, then back to IDLE.
//   The gap between two owners is therefore always two cycles (TURN + IDLE).
//
//   Ports
//     IQC    clock, rising edge
//     QRT    asynchronous active-low reset
//     REQ    per-requester lane request
//     DIN    per-requester data bit
//     LAST   per-requester final-bit marker, only meaningful with REQ
//     GNT    registered one-hot grant; all zeros means no owner
//     OQI    registered pad data
//     BUSY   registered, high while in GRANT or TURN
//     OWNER  index of the current or most recent owner
module output_io_arb #(
  parameter int   NREQ     = 4,
  parameter int   MAX_HOLD = 16,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic            IQC,
  input  logic            QRT,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ-1:0] DIN,
  input  logic [NREQ-1:0] LAST,
  output logic [NREQ-1:0] GNT,
  output logic            OQI,
  output logic            BUSY,
  output logic [2:0]      OWNER
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_TURN  = 2'd2;

  localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [1:0]      state, state_nxt;
  logic [2:0]      ptr, ptr_nxt;
  logic [7:0]      hold_cnt, hold_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic            oqi_nxt;
  logic [2:0]      owner_nxt;

  // The owner's signals are picked with the one-hot grant itself. This means
  // non-owner DIN/LAST/REQ can never reach the datapath while GRANT is set.
  logic req_own, din_own, last_own;
  assign req_own  = |(REQ  & GNT);
  assign din_own  = |(DIN  & GNT);
  assign last_own = |(LAST & GNT);

  // Round-robin pick.
  // The request vector is rotated so that bit 0 is PTR. A priority scan of
  // the rotated vector then gives the offset of the winner from PTR.
  logic [2*NREQ-1:0] req_dbl, req_shf;
  logic [NREQ-1:0]   req_rot, win_oh;
  logic [2:0]        win_idx;
  logic              found;

  always_comb begin
    req_dbl = {REQ, REQ};
    req_shf = req_dbl >> ptr;
    req_rot = req_shf[NREQ-1:0];
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_rot[i]) begin
        found   = 1'b1;
        win_idx = 3'((int'(ptr) + i) % NREQ);
      end
    end
    win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = GNT;
    oqi_nxt   = OQI;
    owner_nxt = OWNER;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    case (state)
      S_IDLE: begin
        gnt_nxt = '0;
        oqi_nxt = IDLE_VAL;
        if (found) begin
          owner_nxt = win_idx;
          gnt_nxt   = win_oh;
          hold_nxt  = '0;
          state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        hold_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 8'd1;
        // A dropped request idles the pad on the same edge.
        // LAST and timeout still sample the final bit.
        oqi_nxt  = req_own ? din_own : IDLE_VAL;
        // All three release causes merge into one condition. If several
        // occur on the same edge, the result is still a single release.
        if (!req_own || last_own || (hold_cnt == HOLD_LAST)) begin
          gnt_nxt   = '0;
          ptr_nxt   = 3'((int'(OWNER) + 1) % NREQ);
          state_nxt = S_TURN;
        end
      end
      S_TURN: begin
        gnt_nxt   = '0;
        oqi_nxt   = IDLE_VAL;
        state_nxt = S_IDLE;
      end
      default: begin
        gnt_nxt   = '0;
        oqi_nxt   = IDLE_VAL;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge IQC or negedge QRT) begin
    if (!QRT) begin
      state    <= S_IDLE;
      GNT      <= '0;
      OQI      <= IDLE_VAL;
      BUSY     <= 1'b0;
      OWNER    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      GNT      <= gnt_nxt;
      OQI      <= oqi_nxt;
      // BUSY is decoded from the registered next state, so it lines up with
      // the state register and has no path from any input to the pin.
      BUSY     <= (state_nxt != S_IDLE);
      OWNER    <= owner_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_output_io_arb.sv
// Bench for output_io_arb with NREQ=4, MAX_HOLD=4, IDLE_VAL=0.
// Each scenario pushes the expected {GNT,OQI,BUSY,OWNER} for a cycle at the
// moment it drives that cycle's inputs. It then pops that entry one edge later
// and compares it against the DUT outputs.
module tb_output_io_arb;

  logic       IQC = 1'b0;
  logic       QRT = 1'b1;
  logic [3:0] REQ = '0;
  logic [3:0] DIN = '0;
  logic [3:0] LAST = '0;
  logic [3:0] GNT;
  logic       OQI;
  logic       BUSY;
  logic [2:0] OWNER;

  output_io_arb #(.NREQ(4), .MAX_HOLD(4), .IDLE_VAL(1'b0)) dut (
    .IQC(IQC), .QRT(QRT), .REQ(REQ), .DIN(DIN), .LAST(LAST),
    .GNT(GNT), .OQI(OQI), .BUSY(BUSY), .OWNER(OWNER)
  );

  always #5 IQC = ~IQC;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  logic [9:0] obs;
  assign obs = {GNT, OQI, BUSY, OWNER};

  function automatic logic [9:0] pk(input logic [3:0] g, input logic o,
                                    input logic b, input logic [2:0] w);
    return {g, o, b, w};
  endfunction

  // Leaves the DUT freshly reset, with QRT released on a falling edge.
  task automatic do_reset();
    QRT = 1'b0; REQ = '0; DIN = '0; LAST = '0;
    repeat (2) @(posedge IQC);
    @(negedge IQC);
    QRT = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] e;
    #2 QRT = 1'b0;
    REQ = 4'b1111;
    exp_q.push_back(pk(4'b0000, 1'b0, 1'b0, 3'd0));
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_async got %b want %b", obs, e); end
    exp_q.push_back(pk(4'b0000, 1'b0, 1'b0, 3'd0));
    @(posedge IQC); #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_held got %b want %b", obs, e); end
    @(negedge IQC);
    QRT = 1'b1; REQ = '0;
    exp_q.push_back(pk(4'b0000, 1'b0, 1'b0, 3'd0));
    @(posedge IQC); #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_idle got %b want %b", obs, e); end
  endtask

  task automatic test_single();
    logic [3:0] rq[6], dn[6], lt[6];
    logic [9:0] ex[6];
    logic [9:0] e;
    int busy_cnt;
    do_reset();
    busy_cnt = 0;
    rq = '{4'b0100, 4'b1101, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    dn = '{4'b1011, 4'b0100, 4'b1011, 4'b0100, 4'b0000, 4'b0000};
    lt = '{4'b1011, 4'b1011, 4'b1011, 4'b0100, 4'b0000, 4'b0000};
    ex = '{pk(4'b0100, 1'b0, 1'b1, 3'd2), pk(4'b0100, 1'b1, 1'b1, 3'd2),
           pk(4'b0100, 1'b0, 1'b1, 3'd2), pk(4'b0000, 1'b1, 1'b1, 3'd2),
           pk(4'b0000, 1'b0, 1'b0, 3'd2), pk(4'b0000, 1'b0, 1'b0, 3'd2)};
    for (int i = 0; i < 6; i++) begin
      REQ = rq[i]; DIN = dn[i]; LAST = lt[i];
      exp_q.push_back(ex[i]);
      @(posedge IQC); #1;
      if (BUSY === 1'b1) busy_cnt++;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL single c%0d got %b want %b", i, obs, e); end
    end
    checks++;
    if (busy_cnt !== 4) begin errors++; $display("FAIL single_busy_cycles got %0d want 4", busy_cnt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] din_pat;
    logic [9:0] e;
    int o;
    do_reset();
    din_pat = 4'b0101;
    REQ = 4'b1111; DIN = din_pat; LAST = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      o = k % 4;
      for (int ph = 0; ph < 3; ph++) begin
        case (ph)
          0: exp_q.push_back(pk(4'(1 << o), 1'b0, 1'b1, 3'(o)));
          1: exp_q.push_back(pk(4'b0000, din_pat[o], 1'b1, 3'(o)));
          default: exp_q.push_back(pk(4'b0000, 1'b0, 1'b0, 3'(o)));
        endcase
        @(posedge IQC); #1;
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL rr k%0d ph%0d got %b want %b", k, ph, obs, e); end
      end
    end
    REQ = '0; LAST = '0;
  endtask

  task automatic test_timeout();
    logic [3:0] rq[15], dn[15];
    logic [9:0] ex[15];
    logic [9:0] e;
    do_reset();
    rq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
           4'b0010, 4'b0010, 4'b0010, 4'b0111, 4'b0111, 4'b0000, 4'b0000};
    dn = '{4'b0010, 4'b1111, 4'b1101, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b1111,
           4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000};
    ex = '{pk(4'b0010, 1'b0, 1'b1, 3'd1), pk(4'b0010, 1'b1, 1'b1, 3'd1),
           pk(4'b0010, 1'b0, 1'b1, 3'd1), pk(4'b0010, 1'b1, 1'b1, 3'd1),
           pk(4'b0000, 1'b1, 1'b1, 3'd1), pk(4'b0000, 1'b0, 1'b0, 3'd1),
           pk(4'b0010, 1'b0, 1'b1, 3'd1), pk(4'b0010, 1'b1, 1'b1, 3'd1),
           pk(4'b0010, 1'b1, 1'b1, 3'd1), pk(4'b0010, 1'b1, 1'b1, 3'd1),
           pk(4'b0000, 1'b1, 1'b1, 3'd1), pk(4'b0000, 1'b0, 1'b0, 3'd1),
           pk(4'b0100, 1'b0, 1'b1, 3'd2), pk(4'b0000, 1'b0, 1'b1, 3'd2),
           pk(4'b0000, 1'b0, 1'b0, 3'd2)};
    for (int i = 0; i < 15; i++) begin
      REQ = rq[i]; DIN = dn[i]; LAST = '0;
      exp_q.push_back(ex[i]);
      @(posedge IQC); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL timeout c%0d got %b want %b", i, obs, e); end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] rq[7], dn[7], lt[7];
    logic [9:0] ex[7];
    logic [9:0] e;
    do_reset();
    rq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0011};
    dn = '{4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    lt = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    ex = '{pk(4'b0001, 1'b0, 1'b1, 3'd0), pk(4'b0001, 1'b1, 1'b1, 3'd0),
           pk(4'b0001, 1'b0, 1'b1, 3'd0), pk(4'b0001, 1'b1, 1'b1, 3'd0),
           pk(4'b0000, 1'b1, 1'b1, 3'd0), pk(4'b0000, 1'b0, 1'b0, 3'd0),
           pk(4'b0010, 1'b0, 1'b1, 3'd1)};
    for (int i = 0; i < 7; i++) begin
      REQ = rq[i]; DIN = dn[i]; LAST = lt[i];
      exp_q.push_back(ex[i]);
      @(posedge IQC); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL simul c%0d got %b want %b", i, obs, e); end
    end
  endtask

  task automatic test_early_drop();
    logic [3:0] rq[4], dn[4];
    logic [9:0] ex[4];
    logic [9:0] e;
    do_reset();
    rq = '{4'b1000, 4'b1000, 4'b0000, 4'b0000};
    dn = '{4'b1111, 4'b1111, 4'b1111, 4'b0000};
    ex = '{pk(4'b1000, 1'b0, 1'b1, 3'd3), pk(4'b1000, 1'b1, 1'b1, 3'd3),
           pk(4'b0000, 1'b0, 1'b1, 3'd3), pk(4'b0000, 1'b0, 1'b0, 3'd3)};
    for (int i = 0; i < 4; i++) begin
      REQ = rq[i]; DIN = dn[i]; LAST = '0;
      exp_q.push_back(ex[i]);
      @(posedge IQC); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL drop c%0d got %b want %b", i, obs, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] e;
    do_reset();
    REQ = 4'b1000; DIN = 4'b1000; LAST = '0;
    exp_q.push_back(pk(4'b1000, 1'b0, 1'b1, 3'd3));
    @(posedge IQC); #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rstmid grant got %b want %b", obs, e); end
    exp_q.push_back(pk(4'b1000, 1'b1, 1'b1, 3'd3));
    @(posedge IQC); #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rstmid data got %b want %b", obs, e); end
    QRT = 1'b0; REQ = 4'b1010;
    exp_q.push_back(pk(4'b0000, 1'b0, 1'b0, 3'd0));
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rstmid async got %b want %b", obs, e); end
    exp_q.push_back(pk(4'b0000, 1'b0, 1'b0, 3'd0));
    @(posedge IQC); #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rstmid held got %b want %b", obs, e); end
    @(negedge IQC);
    QRT = 1'b1;
    exp_q.push_back(pk(4'b0010, 1'b0, 1'b1, 3'd1));
    @(posedge IQC); #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rstmid regrant got %b want %b", obs, e); end
    REQ = '0; DIN = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_simultaneous();
    test_early_drop();
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
